// File: rtl/demultiplexer_pkg.sv
// Shared constants for the four-channel demultiplexer and its holding slots.
package demultiplexer_pkg;

  localparam int NUM_CHANNELS     = 4;
  localparam int SEL_WIDTH        = 2;
  localparam int DROP_COUNT_WIDTH = 8;

  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT_MAX = '1;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: a data register plus valid flag.
// A load always wins over a take, so a same-cycle drain and fill reloads without a bubble.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demultiplexer.sv
// Routes one input word per cycle to one of four independent one-entry output slots,
// counting words refused because the addressed slot is full and not draining.
module demultiplexer
  import demultiplexer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  input  logic [SEL_WIDTH-1:0]        in_select,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data0,
  output logic [WIDTH-1:0]            out_data1,
  output logic [WIDTH-1:0]            out_data2,
  output logic [WIDTH-1:0]            out_data3,
  output logic [NUM_CHANNELS-1:0]     out_valid,
  input  logic [NUM_CHANNELS-1:0]     out_ready,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  logic [NUM_CHANNELS-1:0] load;
  logic [NUM_CHANNELS-1:0] take;
  logic [WIDTH-1:0]        slot_data [NUM_CHANNELS];

  // Reset clears every valid bit, so in_ready naturally reads 1 while rst_n is low.
  assign in_ready = !out_valid[in_select] | out_ready[in_select];
  assign take     = out_valid & out_ready;

  always_comb begin
    load = '0;
    if (in_valid && in_ready) begin
      load[in_select] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (in_data),
      .take      (take[i]),
      .data      (slot_data[i]),
      .valid     (out_valid[i])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

  // Saturating count of refused input cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (in_valid && !in_ready && drop_count != DROP_COUNT_MAX) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demultiplexer.sv
// Self-checking bench for demultiplexer: per-channel scoreboard queues filled on accepted
// input words and drained as consumers take them, plus directed scenario checks.
module tb_demultiplexer;
  import demultiplexer_pkg::*;

  localparam int WIDTH = 8;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [WIDTH-1:0]            in_data = '0;
  logic                        in_valid = 1'b0;
  logic [SEL_WIDTH-1:0]        in_select = '0;
  logic                        in_ready;
  logic [WIDTH-1:0]            out_data0, out_data1, out_data2, out_data3;
  logic [NUM_CHANNELS-1:0]     out_valid;
  logic [NUM_CHANNELS-1:0]     out_ready = '0;
  logic [DROP_COUNT_WIDTH-1:0] drop_count;

  logic [WIDTH-1:0] obs_data [NUM_CHANNELS];
  assign obs_data[0] = out_data0;
  assign obs_data[1] = out_data1;
  assign obs_data[2] = out_data2;
  assign obs_data[3] = out_data3;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb_q [NUM_CHANNELS][$];
  logic [WIDTH-1:0] model_data [NUM_CHANNELS];
  int               model_drop = 0;
  logic             last_refused = 1'b0;

  demultiplexer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_select  (in_select),
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of stimulus after the falling edge, checks the current state
  // against the model, then advances the model as the coming rising edge will.
  task automatic applyStimulus(input logic v, input logic [SEL_WIDTH-1:0] sel,
                               input logic [WIDTH-1:0] d, input logic [NUM_CHANNELS-1:0] rdy);
    logic [NUM_CHANNELS-1:0] exp_valid;
    logic                    exp_ready;
    logic [WIDTH-1:0]        head;
    @(negedge clk);
    in_valid  = v;
    in_select = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
    for (int n = 0; n < NUM_CHANNELS; n++) exp_valid[n] = (sb_q[n].size() != 0);
    exp_ready = !exp_valid[sel] || rdy[sel];
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("drop_count", 32'(drop_count), 32'(model_drop));
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      checkOutput($sformatf("out_data%0d", n), 32'(obs_data[n]), 32'(model_data[n]));
      if (exp_valid[n] && rdy[n]) begin
        head = sb_q[n].pop_front();
        checkOutput($sformatf("drain%0d", n), 32'(obs_data[n]), 32'(head));
      end
    end
    if (v && exp_ready) begin
      sb_q[sel].push_back(d);
      model_data[sel] = d;
    end
    if (v && !exp_ready && model_drop < 255) model_drop++;
    last_refused = v && !exp_ready;
  endtask

  task automatic idle(input logic [NUM_CHANNELS-1:0] rdy);
    applyStimulus(1'b0, '0, '0, rdy);
  endtask

  // Asserts reset between edges with a word presented; everything must clear at once.
  task automatic pulseReset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_select = 2'd3;
    in_data   = 8'h77;
    out_ready = '0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_drop_count", 32'(drop_count), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      checkOutput($sformatf("rst_out_data%0d", n), 32'(obs_data[n]), 32'h0);
      sb_q[n].delete();
      model_data[n] = '0;
    end
    model_drop   = 0;
    last_refused = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    logic                 rv;
    logic [SEL_WIDTH-1:0] rs;
    logic [WIDTH-1:0]     rd;
    for (int n = 0; n < NUM_CHANNELS; n++) model_data[n] = '0;

    #7;
    checkOutput("init_out_valid", 32'(out_valid), 32'h0);
    checkOutput("init_drop_count", 32'(drop_count), 32'h0);
    checkOutput("init_in_ready", 32'(in_ready), 32'h1);
    #6;
    rst_n = 1'b1;

    // Single route to channel 2
    applyStimulus(1'b1, 2'd2, 8'hA5, 4'b0000);
    idle(4'b0000);
    checkOutput("route_out_valid", 32'(out_valid), 32'h4);
    checkOutput("route_out_data2", 32'(out_data2), 32'hA5);
    checkOutput("route_out_data0", 32'(out_data0), 32'h0);
    idle(4'b0100);

    // Backpressure and hold on channel 1
    applyStimulus(1'b1, 2'd1, 8'h11, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd1, 8'h22, 4'b0000);
    applyStimulus(1'b1, 2'd1, 8'h22, 4'b0010);
    checkOutput("bp_in_ready", 32'(in_ready), 32'h1);
    checkOutput("bp_drop_count", 32'(drop_count), 32'h3);
    checkOutput("bp_hold_data1", 32'(out_data1), 32'h11);
    idle(4'b0000);
    checkOutput("bp_out_data1", 32'(out_data1), 32'h22);
    idle(4'b0010);

    // Same-cycle drain and fill on channel 0
    applyStimulus(1'b1, 2'd0, 8'h01, 4'b0000);
    applyStimulus(1'b1, 2'd0, 8'h02, 4'b0001);
    idle(4'b0000);
    checkOutput("df_out_valid0", 32'(out_valid[0]), 32'h1);
    checkOutput("df_out_data0", 32'(out_data0), 32'h02);

    // Fill all channels, then drain only 1 and 3 (channel 0 refill is accepted in-cycle)
    idle(4'b0001);
    for (int i = 0; i < NUM_CHANNELS; i++)
      applyStimulus(1'b1, SEL_WIDTH'(i), 8'(8'h10 + i), 4'b0000);
    idle(4'b1010);
    idle(4'b0000);
    checkOutput("ind_out_valid", 32'(out_valid), 32'h5);
    checkOutput("ind_out_data0", 32'(out_data0), 32'h10);
    checkOutput("ind_out_data2", 32'(out_data2), 32'h12);

    // Saturation: channel 0 stays full and blocked
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 2'd0, 8'hEE, 4'b0000);
    idle(4'b0000);
    checkOutput("sat_drop_count", 32'(drop_count), 32'hFF);
    applyStimulus(1'b1, 2'd2, 8'hEE, 4'b0000);
    idle(4'b0000);
    checkOutput("sat_hold", 32'(drop_count), 32'hFF);

    // Reset mid-operation with every slot full
    applyStimulus(1'b1, 2'd1, 8'h31, 4'b0000);
    applyStimulus(1'b1, 2'd3, 8'h33, 4'b0000);
    idle(4'b0000);
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'hF);
    pulseReset();
    applyStimulus(1'b1, 2'd1, 8'h5A, 4'b0000);
    idle(4'b0000);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'h2);
    checkOutput("post_rst_out_data1", 32'(out_data1), 32'h5A);

    // Random traffic, holding a refused word stable until accepted
    rv = 1'b0;
    rs = '0;
    rd = '0;
    for (int i = 0; i < 200; i++) begin
      if (!last_refused) begin
        rv = 1'($urandom_range(0, 1));
        rs = SEL_WIDTH'($urandom_range(0, 3));
        rd = WIDTH'($urandom);
      end
      applyStimulus(rv, rs, rd, NUM_CHANNELS'($urandom));
    end
    idle(4'b1111);
    idle(4'b0000);
    checkOutput("final_out_valid", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demultiplexer.md
DEMULTIPLEXER -- requirements
Module: demultiplexer

Interface
REQ-001 WIDTH, 8, data width of the input and of each output channel, in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  WIDTH  word to be routed.
REQ-005 in_valid  input  1  in_data and in_select are valid this cycle.
REQ-006 in_select  input  2  destination channel 0..3.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 out_data0..out_data3  output  WIDTH each  held word for channels 0..3.
REQ-009 out_valid  output  4  bit n set = out_data<n> holds an undelivered word.
REQ-010 out_ready  input  4  bit n set = consumer n accepts out_data<n> this cycle.
REQ-011 drop_count  output  8  count of words refused at the input, i.e. cycles with in_valid=1 and in_ready=0.

Function
REQ-012 Each channel SHALL own one one-entry holding slot (data register plus valid flag).
REQ-013 Input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL be combinational: !out_valid[in_select] | out_ready[in_select].
- in_ready is independent of in_valid.
REQ-015 On an input transfer, slot in_select SHALL load in_data at the clock edge.
- Its out_valid bit SHALL be 1 the next cycle.
- Latency is exactly 1 cycle.
REQ-016 Output transfer on channel n SHALL occur when out_valid[n]=1 and out_ready[n]=1.
- Without a simultaneous load, that edge clears out_valid[n].
REQ-017 Same-channel drain and fill in one cycle SHALL reload the slot with the new word.
- out_valid[n] stays 1, with no bubble.
REQ-018 Channels SHALL be independent; every channel not addressed SHALL drain freely in any cycle.
REQ-019 out_data<n> SHALL hold its value while out_valid[n]=0 or out_ready[n]=0.
- Unselected slots never change.
REQ-020 drop_count SHALL increment by 1 per refused cycle.
- It saturates at 255 and never wraps.
REQ-021 Source rule: in_data and in_select SHALL be held stable while in_valid=1 and in_ready=0.
- The block is not required to detect a violation of this rule.
REQ-022 No output SHALL depend combinationally on in_data.
- Only in_ready is combinational, and only from in_select, out_valid and out_ready.

Reset
REQ-023 rst_n low SHALL immediately, asynchronously, clear out_valid to 4'b0000, all out_data to 0 and drop_count to 0.
REQ-024 While rst_n is low, in_ready SHALL read 1 but no transfer occurs; words presented are lost.
- Reset mid-transfer discards slot contents.
REQ-025 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 A shared package SHALL hold the following constants:
- NUM_CHANNELS = 4.
- SEL_WIDTH = 2.
- DROP_COUNT_WIDTH = 8.
REQ-027 The one-entry slot SHALL be a sub-module demux_slot, instantiated 4 times.
- Ports: clk, rst_n, load, load_data, take, data, valid.
REQ-028 Top-level logic SHALL contain the select decode, in_ready generation and drop counter.

Verification
REQ-029 Single route:
- Stimulus: reset; in_select=2, in_data=8'hA5, in_valid=1 one cycle, out_ready=4'b0000.
- Response: next cycle out_valid=4'b0100, out_data2=8'hA5, other outputs 0.
REQ-030 Backpressure and hold:
- Stimulus: channel 1 full with 8'h11, out_ready[1]=0; present 8'h22 to channel 1 for 3 cycles.
- Response: in_ready=0 and out_data1 stays 8'h11; drop_count=3.
- Then out_ready[1]=1: same cycle in_ready=1, next cycle out_data1=8'h22.
REQ-031 Simultaneous drain/fill:
- Stimulus: channel 0 holds 8'h01, out_ready[0]=1, input 8'h02 to channel 0 in the same cycle.
- Response: out_valid[0] remains 1 with no gap; out_data0=8'h02.
REQ-032 Independence:
- Stimulus: fill channels 0-3 with 8'h10..8'h13 on consecutive cycles; out_ready=4'b1010 for one cycle.
- Response: out_valid=4'b0101; out_data0=8'h10, out_data2=8'h12.
REQ-033 Saturation:
- Stimulus: hold a refused input for 300 cycles.
- Response: drop_count reaches 255 and stays at 255.
REQ-034 Reset mid-operation:
- Stimulus: all slots full; pulse rst_n low between clock edges.
- Response: out_valid=0, all out_data=0 and drop_count=0 immediately, before the next edge.
